// File: rtl/datapath_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : datapath_multiciclo
// Brief    : Multi-cycle MIPS-subset CPU. One ALU, one register file and a
//            single unified instruction/data memory port with a req/ready
//            handshake, sequenced by a START/FETCH/DECODE/EXEC/MEM/WB/HALT
//            state machine. Counts retired instructions.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_multiciclo #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic [CNT_W-1:0]  instret,
    output logic              halted
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_START  = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_MEM    = 3'd4;
    localparam logic [2:0] c_WB     = 3'd5;
    localparam logic [2:0] c_HALT   = 3'd6;

    // Opcodes and R-type function codes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    // ------------------------------------------------------------------
    // Architectural and micro-architectural registers
    // ------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_ir;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_aluout;
    logic [31:0]      r_mdr;
    logic [31:0]      r_rf [32];
    logic [CNT_W-1:0] r_instret;

    // ------------------------------------------------------------------
    // Instruction field decode (IR is stable from DECODE onwards)
    // ------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic [25:0] w_target;
    logic        w_is_rtype;
    logic        w_is_addi;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_beq;
    logic        w_is_j;
    logic        w_legal;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_target   = r_ir[25:0];

    // Unknown functs make the whole R-type illegal so it falls into HALT
    assign w_is_rtype = (w_op == c_OP_RTYPE) &&
                        ((w_funct == c_FN_ADD) || (w_funct == c_FN_SUB) ||
                         (w_funct == c_FN_AND) || (w_funct == c_FN_OR)  ||
                         (w_funct == c_FN_SLT));
    assign w_is_addi  = (w_op == c_OP_ADDI);
    assign w_is_lw    = (w_op == c_OP_LW);
    assign w_is_sw    = (w_op == c_OP_SW);
    assign w_is_beq   = (w_op == c_OP_BEQ);
    assign w_is_j     = (w_op == c_OP_J);
    assign w_legal    = w_is_rtype || w_is_addi || w_is_lw || w_is_sw ||
                        w_is_beq || w_is_j;

    // ------------------------------------------------------------------
    // ALU and PC targets
    // ------------------------------------------------------------------
    logic [31:0] w_alu_res;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    // PC already holds PC+4 when EXEC runs, so both targets build on it
    assign w_br_target = r_pc + {w_imm_sext[29:0], 2'b00};
    assign w_j_target  = {r_pc[31:28], w_target, 2'b00};

    // ALU: R-type ops on A/B, everything else is A + sign-extended immediate
    always_comb begin
        w_alu_res = r_a + w_imm_sext;
        if (w_op == c_OP_RTYPE) begin
            case (w_funct)
                c_FN_SUB: w_alu_res = r_a - r_b;
                c_FN_AND: w_alu_res = r_a & r_b;
                c_FN_OR:  w_alu_res = r_a | r_b;
                c_FN_SLT: w_alu_res = {31'b0, ($signed(r_a) < $signed(r_b))};
                default:  w_alu_res = r_a + r_b;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register-file write port (WB only)
    // ------------------------------------------------------------------
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;

    assign w_rf_we    = (r_state == c_WB);
    assign w_rf_waddr = w_is_rtype ? w_rd : w_rt;
    assign w_rf_wdata = w_is_lw ? r_mdr : r_aluout;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_START;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; memory states wait for mem_ready
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_START:  w_next_state = c_FETCH;
            c_FETCH:  if (mem_ready) w_next_state = c_DECODE;
            c_DECODE: w_next_state = w_legal ? c_EXEC : c_HALT;
            c_EXEC: begin
                if (w_is_rtype || w_is_addi)  w_next_state = c_WB;
                else if (w_is_lw || w_is_sw)  w_next_state = c_MEM;
                else if (w_is_beq || w_is_j)  w_next_state = c_FETCH;
                else                          w_next_state = c_HALT;
            end
            c_MEM:    if (mem_ready) w_next_state = w_is_lw ? c_WB : c_FETCH;
            c_WB:     w_next_state = c_FETCH;
            c_HALT:   w_next_state = c_HALT;
            default:  w_next_state = c_START;
        endcase
    end

    // Memory port and status outputs, decoded from state and registers only
    logic [31:0] w_addr_full;

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        w_addr_full = 32'h0;
        mem_wdata   = 32'h0;
        halted      = 1'b0;
        case (r_state)
            c_FETCH: begin
                mem_req     = 1'b1;
                w_addr_full = {r_pc[31:2], 2'b00};
            end
            c_MEM: begin
                mem_req     = 1'b1;
                mem_we      = w_is_sw;
                w_addr_full = {r_aluout[31:2], 2'b00};
                mem_wdata   = w_is_sw ? r_b : 32'h0;
            end
            c_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr = w_addr_full[ADDR_W-1:0];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // PC, IR, operand latches, ALU result and memory data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= PC_RESET;
            r_ir     <= 32'h0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_aluout <= 32'h0;
            r_mdr    <= 32'h0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                c_DECODE: begin
                    r_a <= r_rf[w_rs];
                    r_b <= r_rf[w_rt];
                end
                c_EXEC: begin
                    r_aluout <= w_alu_res;
                    if (w_is_beq && (r_a == r_b)) r_pc <= w_br_target;
                    if (w_is_j)                   r_pc <= w_j_target;
                end
                c_MEM: begin
                    if (mem_ready && w_is_lw) r_mdr <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Register file; $0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0;
            end
        end else if (w_rf_we && (w_rf_waddr != 5'd0)) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // Retired-instruction counter: bumps when EXEC/MEM/WB hands back to FETCH
    logic w_retire;

    assign w_retire = (w_next_state == c_FETCH) &&
                      ((r_state == c_EXEC) || (r_state == c_MEM) || (r_state == c_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign pc      = r_pc;
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_datapath_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_multiciclo
// Brief    : Self-checking bench for datapath_multiciclo with a behavioural
//            memory responder and an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_multiciclo;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;
    localparam int          ADDR_W   = 32;
    localparam int          CNT_W    = 32;
    localparam int          LIMIT    = 4000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic              mem_ready = 1'b0;
    logic [31:0]       pc;
    logic [CNT_W-1:0]  instret;
    logic              halted;

    always #5 clk = ~clk;

    datapath_multiciclo #(.PC_RESET(PC_RESET), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .instret(instret), .halted(halted)
    );

    typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} st_t;
    typedef struct {logic [31:0] addr; logic we; int dur;} tx_t;

    // Memory image (main writes img; the responder owns mem)
    logic [31:0] img [1024];
    logic [31:0] mem [1024];
    logic [31:0] mm  [1024];
    int  load_gen = 0, seen_gen = 0;
    bit  force_ready = 0, rnd_wait = 0, stall_data = 0;
    int  rd_wait = 0;
    st_t st_log[$];
    tx_t tx_log[$];
    int  cyc = 0, waits = 0, hs_viol = 0, dur = 0;
    bit  pending = 0, rsp_go, rsp_data;
    logic        saved_we;
    logic [31:0] saved_addr, saved_wdata;

    // Memory responder: acts on the falling edge, DUT samples on the rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            if (seen_gen != load_gen) begin
                mem = img;
                seen_gen = load_gen;
            end
            st_log.delete(); tx_log.delete();
            cyc = 0; waits = 0; hs_viol = 0; pending = 0; dur = 0;
            mem_ready = force_ready;
            mem_rdata = $urandom;
        end else begin
            cyc++;
            if (pending && (mem_req !== 1'b1 || mem_we !== saved_we ||
                            mem_addr !== saved_addr || mem_wdata !== saved_wdata))
                hs_viol++;
            if (mem_req === 1'b1) begin
                dur++;
                rsp_data = (mem_addr >= 32'h100);
                rsp_go = 1'b1;
                if (stall_data && rsp_data)                        rsp_go = 1'b0;
                else if (!mem_we && rsp_data && dur <= rd_wait)    rsp_go = 1'b0;
                else if (rnd_wait && $urandom_range(0, 3) == 0)   rsp_go = 1'b0;
                mem_ready = rsp_go;
                mem_rdata = rsp_go ? mem[mem_addr[11:2]] : $urandom;
                if (rsp_go) begin
                    if (mem_we) begin
                        mem[mem_addr[11:2]] = mem_wdata;
                        st_log.push_back('{mem_addr, mem_wdata, cyc});
                    end
                    tx_log.push_back('{mem_addr, mem_we, dur});
                    dur = 0; pending = 0;
                end else begin
                    waits++; pending = 1;
                    saved_we = mem_we; saved_addr = mem_addr; saved_wdata = mem_wdata;
                end
            end else begin
                dur = 0; pending = 0;
                mem_ready = force_ready | (rnd_wait & ($urandom_range(0, 1) == 1));
                mem_rdata = $urandom;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic fill_img();
        for (int i = 0; i < 512; i++)    img[i] = 32'hFC00_0000;
        for (int i = 512; i < 1024; i++) img[i] = $urandom;
    endtask

    // ------------------------------------------------------------------
    // Instruction-level reference model (ISA semantics + cycle cost)
    // ------------------------------------------------------------------
    st_t exp_st[$];
    int  m_instret, m_cycles;
    logic [31:0] m_pc;

    task automatic run_model();
        logic [31:0] r [32];
        logic [31:0] p, ir, a, b, se, ad, res;
        bit done;
        mm = img;
        exp_st.delete();
        m_instret = 0; m_cycles = 1;
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        p = PC_RESET;
        for (int g = 0; g < 10000; g++) begin
            ir = mm[p[11:2]];
            p = p + 32'd4;
            a = r[ir[25:21]]; b = r[ir[20:16]];
            se = {{16{ir[15]}}, ir[15:0]};
            ad = (a + se) & 32'hFFFF_FFFC;
            done = 0; res = 32'h0;
            case (ir[31:26])
                6'h00: begin
                    case (ir[5:0])
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: done = 1;
                    endcase
                    if (!done) begin
                        if (ir[15:11] != 5'd0) r[ir[15:11]] = res;
                        m_cycles += 4;
                    end
                end
                6'h08: begin if (ir[20:16] != 5'd0) r[ir[20:16]] = a + se; m_cycles += 4; end
                6'h23: begin if (ir[20:16] != 5'd0) r[ir[20:16]] = mm[ad[11:2]]; m_cycles += 5; end
                6'h2B: begin mm[ad[11:2]] = b; exp_st.push_back('{ad, b, 0}); m_cycles += 4; end
                6'h04: begin if (a == b) p = p + (se << 2); m_cycles += 3; end
                6'h02: begin p = {p[31:28], ir[25:0], 2'b00}; m_cycles += 3; end
                default: done = 1;
            endcase
            if (done) begin
                m_cycles += 2;
                break;
            end
            m_instret++;
        end
        m_pc = p;
    endtask

    // ------------------------------------------------------------------
    // Sequencing helpers
    // ------------------------------------------------------------------
    task automatic apply_reset();
        @(negedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input string tag, input int start, output int n);
        bit to;
        n = start; to = 1;
        for (int k = 0; k < LIMIT; k++) begin
            if (halted === 1'b1) begin to = 0; break; end
            @(negedge clk); n++;
        end
        if (halted === 1'b1) to = 0;
        check({tag, ".timeout"}, 64'(to), 64'(0));
    endtask

    task automatic compare_run(input string tag, input int n);
        int errs;
        run_model();
        check({tag, ".cycles"},  64'(n), 64'(m_cycles + waits));
        check({tag, ".instret"}, 64'(instret), 64'(m_instret));
        check({tag, ".pc"},      64'(pc), 64'(m_pc));
        check({tag, ".halted"},  64'(halted), 64'(1));
        check({tag, ".nstores"}, 64'(st_log.size()), 64'(exp_st.size()));
        errs = 0;
        for (int i = 0; i < exp_st.size(); i++) begin
            if (i >= st_log.size() || st_log[i].addr !== exp_st[i].addr ||
                st_log[i].data !== exp_st[i].data) errs++;
        end
        check({tag, ".storeseq"}, 64'(errs), 64'(0));
        errs = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== mm[i]) errs++;
        check({tag, ".memory"},    64'(errs), 64'(0));
        check({tag, ".handshake"}, 64'(hs_viol), 64'(0));
    endtask

    // ------------------------------------------------------------------
    // Directed + randomized stimulus
    // ------------------------------------------------------------------
    logic [31:0] exp_a_addr [5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    logic [31:0] exp_a_data [5] = '{32'd2, 32'd2, 32'hFFFF_FFF8, 32'd1, 32'd0};
    logic [5:0]  fn_tab [5]     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        int n, errs, lw_dur;
        logic [CNT_W-1:0] inst_h;
        bit found;

        // ---- Program A: directed arithmetic / memory / branch sequence ----
        fill_img();
        img[0]  = itype(6'h08, 5'd0, 5'd1, 16'd5);
        img[1]  = itype(6'h08, 5'd0, 5'd2, 16'hFFFD);
        img[2]  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        img[3]  = itype(6'h2B, 5'd0, 5'd3, 16'h100);
        img[4]  = itype(6'h23, 5'd0, 5'd4, 16'h100);
        img[5]  = itype(6'h2B, 5'd0, 5'd4, 16'h104);
        img[6]  = rtype(5'd2, 5'd1, 5'd5, 6'h22);
        img[7]  = rtype(5'd5, 5'd1, 5'd6, 6'h2A);
        img[8]  = itype(6'h2B, 5'd0, 5'd5, 16'h108);
        img[9]  = itype(6'h2B, 5'd0, 5'd6, 16'h10C);
        img[10] = itype(6'h08, 5'd0, 5'd0, 16'd7);
        img[11] = itype(6'h2B, 5'd0, 5'd0, 16'h110);
        img[12] = itype(6'h04, 5'd1, 5'd1, 16'd2);
        img[13] = itype(6'h2B, 5'd0, 5'd1, 16'h114);
        img[14] = itype(6'h2B, 5'd0, 5'd1, 16'h114);
        img[15] = itype(6'h04, 5'd1, 5'd2, 16'd5);
        img[16] = {6'h02, 26'h30};
        load_gen++;
        force_ready = 1;

        // Reset held 3 cycles with ready=1
        repeat (3) @(negedge clk);
        check("rst.req",     64'(mem_req),   64'(0));
        check("rst.we",      64'(mem_we),    64'(0));
        check("rst.addr",    64'(mem_addr),  64'(0));
        check("rst.wdata",   64'(mem_wdata), 64'(0));
        check("rst.pc",      64'(pc),        64'(PC_RESET));
        check("rst.instret", 64'(instret),   64'(0));
        check("rst.halted",  64'(halted),    64'(0));

        force_ready = 0;
        rd_wait = 3;
        #2 rst_n = 1'b1;
        #1 check("start.req", 64'(mem_req), 64'(0));
        @(negedge clk);
        check("fetch0.req",  64'(mem_req),  64'(1));
        check("fetch0.addr", 64'(mem_addr), 64'(PC_RESET));
        check("fetch0.we",   64'(mem_we),   64'(0));
        run_to_halt("A", 1, n);
        check("A.cycles_const",  64'(n),       64'(64));
        check("A.instret_const", 64'(instret), 64'(15));
        check("A.pc_const",      64'(pc),      64'(32'hC4));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("A.st%0d.addr", i),
                  (i < st_log.size()) ? 64'(st_log[i].addr) : 64'hx, 64'(exp_a_addr[i]));
            check($sformatf("A.st%0d.data", i),
                  (i < st_log.size()) ? 64'(st_log[i].data) : 64'hx, 64'(exp_a_data[i]));
        end
        check("A.st0.cycle", (st_log.size() > 0) ? 64'(st_log[0].cyc) : 64'hx, 64'(16));
        lw_dur = -1;
        foreach (tx_log[i]) if (tx_log[i].addr == 32'h100 && !tx_log[i].we) lw_dur = tx_log[i].dur;
        check("A.lw.duration", 64'(lw_dur), 64'(4));
        compare_run("A", n);

        // Halt is absorbing: no requests, counter frozen
        inst_h = instret;
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || instret !== inst_h || halted !== 1'b1) errs++;
        end
        check("A.halt_frozen", 64'(errs), 64'(0));

        // ---- Program C: illegal funct halts ----
        fill_img();
        img[0] = itype(6'h08, 5'd0, 5'd1, 16'd1);
        img[1] = rtype(5'd1, 5'd1, 5'd2, 6'h3F);
        load_gen++;
        rd_wait = 0;
        apply_reset();
        run_to_halt("C", 0, n);
        check("C.instret_const", 64'(instret), 64'(1));
        check("C.pc_const",      64'(pc),      64'(8));
        compare_run("C", n);

        // ---- Program D: reset asserted while a store is stalled in MEM ----
        fill_img();
        img[0] = itype(6'h08, 5'd0, 5'd1, 16'd9);
        img[1] = itype(6'h2B, 5'd0, 5'd1, 16'h800);
        load_gen++;
        stall_data = 1;
        apply_reset();
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b1) begin found = 1; break; end
        end
        check("D.store_seen", 64'(found), 64'(1));
        repeat (2) @(negedge clk);
        check("D.stall_req",    64'(mem_req),   64'(1));
        check("D.stall_addr",   64'(mem_addr),  64'(32'h800));
        check("D.stall_wdata",  64'(mem_wdata), 64'(9));
        check("D.pre_instret",  64'(instret),   64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("D.abort.req",     64'(mem_req),   64'(0));
        check("D.abort.we",      64'(mem_we),    64'(0));
        check("D.abort.addr",    64'(mem_addr),  64'(0));
        check("D.abort.wdata",   64'(mem_wdata), 64'(0));
        check("D.abort.pc",      64'(pc),        64'(PC_RESET));
        check("D.abort.instret", 64'(instret),   64'(0));
        check("D.abort.mem",     64'(mem[32'h800 >> 2]), 64'(img[32'h800 >> 2]));
        stall_data = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        run_to_halt("D", 0, n);
        check("D.instret_const", 64'(instret), 64'(2));
        check("D.mem_const",     64'(mem[32'h800 >> 2]), 64'(9));
        compare_run("D", n);

        // ---- Randomized programs with random wait states ----
        rnd_wait = 1;
        for (int p = 0; p < 4; p++) begin
            fill_img();
            for (int i = 0; i < 24; i++) begin
                int k;
                logic [4:0] rs, rt, rd;
                k  = $urandom_range(0, 9);
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
                case (k)
                    0, 1, 2, 3, 4: img[i] = rtype(rs, rt, rd, fn_tab[k]);
                    5: img[i] = itype(6'h08, rs, rt, 16'($urandom));
                    6: img[i] = itype(6'h23, 5'd0, rt, 16'(32'h800 + $urandom_range(0, 32'h7FF)));
                    7: img[i] = itype(6'h2B, 5'd0, rt, 16'(32'h800 + $urandom_range(0, 32'h7FF)));
                    8: img[i] = itype(6'h04, rs, rt, 16'($urandom_range(0, 2)));
                    default: img[i] = {6'h02, 26'(i + 2)};
                endcase
            end
            load_gen++;
            apply_reset();
            run_to_halt($sformatf("R%0d", p), 0, n);
            compare_run($sformatf("R%0d", p), n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
